// File: rtl/uart_rx_ram_loader.sv
// uart_rx_ram_loader: receives UART bytes from the PC and writes them to consecutive
// image-RAM addresses starting at 0. It raises a sticky done flag after NUM_BYTES writes.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing. Without it the frame is 8N1.
module uart_rx_ram_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 16,
    parameter int NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ram_act,
    input  logic              rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_WAITHI = 3'd6;

    logic              rx_s1_q, rx_s1_d;
    logic              rx_s2_q, rx_s2_d;
    logic              rx_prev_q, rx_prev_d;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              rx_sync;

    assign rx_sync = rx_s2_q;

    // Two-flop synchroniser plus the previous synced value, used for start-edge detection.
    always_comb begin
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
    end

    // Frame FSM, address counter and status flags. A low pc_ram_act overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        done_d  = done_q;
        busy_d  = busy_q;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // A start needs a real 1->0 edge. A line that is already low is ignored.
                if (!rx_sync && rx_prev_q && !done_q)
                    state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d = S_DATA;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;  // glitch shorter than half a bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync, shreg_q[7:1]};  // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_sync;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        // Bad stop bit: drop the byte. Wait for idle so a break cannot retrigger.
                        ferr_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_WAITHI;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shreg_q) ^ par_q) begin
                        ferr_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
`endif
                    end else begin
                        state_d = S_WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                // The last address sets done and holds. The counter never wraps.
                if (addr_q == ADDR_LAST)
                    done_d = 1'b1;
                else
                    addr_d = addr_q + ADDR_W'(1);
            end
            S_WAITHI: begin
                if (rx_sync)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!pc_ram_act) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            addr_d  = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    // State registers. The synchroniser resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // The write strobe is gated by pc_ram_act, so an abort during WRITE issues no write.
    assign ram_we    = (state_q == S_WRITE) && pc_ram_act;
    assign ram_addr  = addr_q;
    assign ram_din   = shreg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// Bench for uart_rx_ram_loader. It sends directed and random UART frames and compares the
// RAM writes and status flags against a byte-level model of the loader.
module tb_uart_rx_ram_loader;
    localparam int CPB = 16;
    localparam int AW  = 4;
    localparam int NB  = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pc_ram_act = 1'b0;
    logic          rx = 1'b1;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          busy, done, frame_err;

    uart_rx_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .pc_ram_act(pc_ram_act), .rx(rx),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every write and count frame_err pulses and busy cycles.
    int   wa[$], wd[$], wc[$];
    int   fe_cnt = 0, fe_long = 0, busy_cnt = 0;
    logic fe_prev = 1'b0;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wa.push_back(int'(ram_addr));
            wd.push_back(int'(ram_din));
            wc.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (frame_err === 1'b1 && fe_prev === 1'b1) fe_long <= fe_long + 1;
        fe_prev <= frame_err;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    // Reference model: good bytes land at successive addresses until NB bytes are written.
    int ea[$], ed[$];
    int m_addr = 0;
    bit m_done = 0;
    task automatic m_frame(input logic [7:0] d, input bit good);
        if (good && !m_done) begin
            ea.push_back(m_addr);
            ed.push_back(int'(d));
            if (m_addr == NB - 1) m_done = 1;
            else m_addr++;
        end
    endtask
    task automatic m_abort();
        m_addr = 0;
        m_done = 0;
    endtask

    int errors = 0, checks = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int wr_rd = 0, er_rd = 0;
    task automatic check_writes(input string tag);
        int nobs, nexp;
        nobs = wa.size() - wr_rd;
        nexp = ea.size() - er_rd;
        chk({tag, " nwrites"}, nobs, nexp);
        for (int i = 0; i < nobs && i < nexp; i++) begin
            chk({tag, " addr"}, wa[wr_rd + i], ea[er_rd + i]);
            chk({tag, " data"}, wd[wr_rd + i], ed[er_rd + i]);
        end
        wr_rd = wa.size();
        er_rd = ea.size();
    endtask

    int   start_cyc;
    logic busy_mid;
    // Drive one frame starting at a negedge. abort_bit >= 0 aborts partway through that bit:
    // by dropping pc_ram_act, or with use_rst set by also pulsing rst.
    task automatic send(input logic [7:0] d, input bit stop, input bit pbad,
                        input int abort_bit, input bit use_rst);
        logic [10:0] fb;
        bit aborted;
        aborted = 0;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
`ifdef UART_RX_PARITY_EN
        fb[9]  = (^d) ^ pbad;
        fb[10] = stop;
`else
        fb[9]  = stop;
`endif
        start_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            rx = fb[i];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (i == 5 && k == 7) busy_mid = busy;
                if (i == abort_bit && k == 7) begin
                    aborted = 1;
                    pc_ram_act = 1'b0;
                    if (use_rst) begin
                        rst = 1'b1;
                        #1;
                        chk("rst busy immediate", int'(busy), 0);
                        chk("rst ram_we immediate", int'(ram_we), 0);
                    end
                    m_abort();
                end
                if (i == abort_bit && k == 8) begin
                    rst = 1'b0;
                    chk("abort busy", int'(busy), 0);
                    chk("abort addr", int'(ram_addr), 0);
                    chk("abort done", int'(done), 0);
                end
            end
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        if (aborted) pc_ram_act = 1'b1;
        else m_frame(d, stop && !pbad);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_abort();
        @(negedge clk);
        pc_ram_act = 1'b0;
        @(negedge clk);
        chk("clear addr", int'(ram_addr), 0);
        chk("clear done", int'(done), 0);
        pc_ram_act = 1'b1;
        m_abort();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int fe0, b0, rel;
        logic [7:0] rb;
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ram_we", int'(ram_we), 0);
        chk("reset ram_addr", int'(ram_addr), 0);
        chk("reset ram_din", int'(ram_din), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset frame_err", int'(frame_err), 0);
        rst = 1'b0;
        pc_ram_act = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single byte
        fe0 = fe_cnt;
        send(8'hA5, 1'b1, 1'b0, -1, 1'b0);
        chk("t1 busy mid-frame", int'(busy_mid), 1);
        chk("t1 busy after", int'(busy), 0);
        chk("t1 frame_err", fe_cnt - fe0, 0);
        if (wa.size() > wr_rd) begin
            rel = wc[wr_rd] - start_cyc;
            chk("t1 write timing", int'(rel >= (NBITS - 1) * CPB + 2 && rel <= NBITS * CPB + 5), 1);
        end
        check_writes("t1");

        // 2: fill the image, then one extra byte is ignored
        do_abort();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0, -1, 1'b0);
        check_writes("t2");
        chk("t2 done", int'(done), 1);
        chk("t2 addr holds", int'(ram_addr), NB - 1);
        send(8'hFF, 1'b1, 1'b0, -1, 1'b0);
        check_writes("t2 extra");
        chk("t2 done sticky", int'(done), 1);

        // 3: glitch rejection
        do_abort();
        fe0 = fe_cnt;
        b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t3 busy cycles", busy_cnt - b0, 0);
        chk("t3 frame_err", fe_cnt - fe0, 0);
        check_writes("t3");

        // 4: bad stop bit, then a good byte at the same address
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        chk("t4 frame_err pulses", fe_cnt - fe0, 1);
        chk("t4 frame_err width", fe_long, 0);
        check_writes("t4 bad");
        send(8'h55, 1'b1, 1'b0, -1, 1'b0);
        check_writes("t4 good");

        // 5: abort mid-DATA on the second byte, then re-enable
        send(8'h99, 1'b1, 1'b0, 3, 1'b0);
        send(8'h77, 1'b1, 1'b0, -1, 1'b0);
        check_writes("t5");

        // Random bytes fill the rest of the image
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b1, 1'b0, -1, 1'b0);
        end
        check_writes("rand fill");
        chk("rand done", int'(done), 1);

        // Async reset mid-frame discards the partial byte
        do_abort();
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b1, 1'b0, 4, 1'b1);
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b1, 1'b0, -1, 1'b0);
        check_writes("after rst");

`ifdef UART_RX_PARITY_EN
        // 6: even parity
        do_abort();
        fe0 = fe_cnt;
        send(8'h03, 1'b1, 1'b0, -1, 1'b0);
        send(8'h03, 1'b1, 1'b1, -1, 1'b0);
        chk("t6 frame_err pulses", fe_cnt - fe0, 1);
        check_writes("t6");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
